alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 205 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus iterative signed
// multiply (shift-add) and divide (restoring), with a registered done/result.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_ITER = SW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR = 5'b00101,
        OP_SHRA = 5'b00110, OP_SHL  = 5'b00111, OP_ROR = 5'b01000,
        OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR  = 5'b01011,
        OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG = 5'b10001,
        OP_NOT  = 5'b10010
    } op_t;

    state_t             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d, mag_q, mag_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   alu_lo;
    logic               alu_ok;
    logic [SW-1:0]      amt, rot_amt;
    logic [SW:0]        inv_amt;
    logic [WIDTH:0]     sum, shifted, trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Single-cycle datapath, evaluated from the captured operands while in DONE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        alu_lo  = '0;
        alu_ok  = 1'b1;
        amt     = b_q[SW-1:0];
        rot_amt = ({1'b0, amt} >= (SW+1)'(WIDTH)) ? amt - SW'(WIDTH) : amt;
        inv_amt = (SW+1)'(WIDTH) - {1'b0, rot_amt};
        case (op_q)
            OP_ADD:  alu_lo = a_q + b_q;
            OP_SUB:  alu_lo = a_q - b_q;
            OP_SHR:  alu_lo = a_q >> amt;
            OP_SHRA: alu_lo = $signed(a_q) >>> amt;
            OP_SHL:  alu_lo = a_q << amt;
            OP_ROR:  alu_lo = (a_q >> rot_amt) | (a_q << inv_amt);
            OP_ROL:  alu_lo = (a_q << rot_amt) | (a_q >> inv_amt);
            OP_AND:  alu_lo = a_q & b_q;
            OP_OR:   alu_lo = a_q | b_q;
            OP_NEG:  alu_lo = -b_q;
            OP_NOT:  alu_lo = ~b_q;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        dbz_d    = dbz_q;
        result_d = result_q;
        done_d   = (state_q == DONE);
        sum      = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mag_q} : '0);
        shifted  = {p_hi_q, p_lo_q[WIDTH-1]};
        trial    = shifted - {1'b0, mag_q};
        prod     = {p_hi_q, p_lo_q};
        quo      = p_lo_q;
        rem      = p_hi_q;

        case (state_q)
            IDLE: begin
                // The cycle carrying the done pulse still refuses a new request.
                if (start && !done_q) begin
                    op_d   = opcode;
                    a_d    = A;
                    b_d    = B;
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    p_hi_d = '0;
                    neg_d  = A[WIDTH-1] ^ B[WIDTH-1];
                    rneg_d = A[WIDTH-1];
                    state_d = DONE;
                    if (opcode == OP_MUL) begin
                        p_lo_d  = mag_of(B);
                        mag_d   = mag_of(A);
                        state_d = ITER;
                    end else if (opcode == OP_DIV) begin
                        if (B == '0) begin
                            p_hi_d = A;
                            p_lo_d = '1;
                            dz_d   = 1'b1;
                        end else begin
                            p_lo_d  = mag_of(A);
                            mag_d   = mag_of(B);
                            state_d = ITER;
                        end
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    p_hi_d = sum[WIDTH:1];
                    p_lo_d = {sum[0], p_lo_q[WIDTH-1:1]};
                end else begin
                    // Remainder stays below the divisor magnitude, so WIDTH bits hold it.
                    p_hi_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    p_lo_d = {p_lo_q[WIDTH-2:0], ~trial[WIDTH]};
                end
                if (cnt_q == LAST_ITER) state_d = FIX;
            end
            FIX: begin
                if (op_q == OP_MUL) begin
                    if (neg_q) prod = -prod;
                    {p_hi_d, p_lo_d} = prod;
                end else begin
                    if (neg_q)  quo = -quo;
                    if (rneg_q) rem = -rem;
                    p_hi_d = rem;
                    p_lo_d = quo;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                dbz_d   = dz_q;
                if (op_q == OP_MUL || op_q == OP_DIV) result_d = {p_hi_q, p_lo_q};
                else if (alu_ok)                      result_d = {{WIDTH{1'b0}}, alu_lo};
                else                                  result_d = '0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || done_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            mag_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result      = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32 and WIDTH=8: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_alu_seq;
    localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, SHR = 5'b00101, SHRA = 5'b00110,
                           SHL = 5'b00111, ROR = 5'b01000, ROL = 5'b01001, AND_ = 5'b01010,
                           OR_ = 5'b01011, MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001,
                           NOT_ = 5'b10010;
    localparam logic [4:0] LEGAL [13] = '{ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND_, OR_,
                                          MUL, DIV, NEG, NOT_};

    logic        clk = 1'b0;
    logic        clr;
    logic        start32, start8;
    logic [4:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    logic [63:0] result32;
    logic [15:0] result8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .clr(clr), .start(start32), .opcode(op32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .div_by_zero(dbz32), .result(result32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .opcode(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .result(result8)
    );

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {div_by_zero, HI:LO} computed with signed 64-bit arithmetic.
    function automatic logic [64:0] ref_model(input int w, input logic [4:0] op,
                                              input logic [31:0] a_in, input logic [31:0] b_in);
        longint unsigned mask, a, b, lo, hi;
        longint sa, sb, t;
        int n;
        logic dz;
        mask = (64'd1 << w) - 64'd1;
        a  = a_in & mask;
        b  = b_in & mask;
        sa = ((a >> (w - 1)) & 1) != 0 ? $signed(a) - $signed(64'd1 << w) : $signed(a);
        sb = ((b >> (w - 1)) & 1) != 0 ? $signed(b) - $signed(64'd1 << w) : $signed(b);
        n  = int'(b & longint'(w - 1));
        lo = 0;
        hi = 0;
        dz = 1'b0;
        case (op)
            ADD:  lo = (a + b) & mask;
            SUB:  lo = (a - b) & mask;
            SHR:  lo = a >> n;
            SHRA: begin t = sa >>> n; lo = t & mask; end
            SHL:  lo = (a << n) & mask;
            ROR:  lo = ((a >> n) | (a << (w - n))) & mask;
            ROL:  lo = ((a << n) | (a >> (w - n))) & mask;
            AND_: lo = a & b;
            OR_:  lo = a | b;
            NEG:  lo = (0 - b) & mask;
            NOT_: lo = ~b & mask;
            MUL:  begin t = sa * sb; lo = t & mask; hi = (t >> w) & mask; end
            DIV: begin
                if (b == 0) begin
                    lo = mask;
                    hi = a;
                    dz = 1'b1;
                end else begin
                    t  = sa / sb;
                    lo = t & mask;
                    t  = sa % sb;
                    hi = t & mask;
                end
            end
            default: ;
        endcase
        return {dz, (hi << w) | lo};
    endfunction

    function automatic int lat_of(input int w, input logic [4:0] op, input logic [31:0] b);
        logic [31:0] bm;
        bm = (w == 32) ? b : {24'd0, b[7:0]};
        if (op == MUL || (op == DIV && bm != 0)) return w + 2;
        return 1;
    endfunction

    function automatic logic [31:0] pick_operand(input int w);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'd1 << (w - 1);
            4:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        return (w == 32) ? done32 : done8;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 32) ? busy32 : busy8;
    endfunction

    function automatic logic [64:0] result_of(input int w);
        return (w == 32) ? {dbz32, result32} : {dbz8, 48'd0, result8};
    endfunction

    task automatic drive_start(input int w, input logic v);
        if (w == 32) start32 = v;
        else         start8  = v;
    endtask

    task automatic run_op(input int w, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noisy, input logic [64:0] exp,
                          input int exp_lat, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        if (w == 32) begin op32 = op; a32 = a; b32 = b; end
        else         begin op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        drive_start(w, 1'b1);
        @(posedge clk);
        #1;
        drive_start(w, 1'b0);
        // Inputs change after acceptance; the operation must use the captured values.
        if (w == 32) begin op32 = 5'($urandom); a32 = $urandom; b32 = $urandom; end
        else         begin op8 = 5'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
        check({tag, " busy"}, 65'(busy_of(w)), 65'd1);
        for (int n = 1; n <= 200; n++) begin
            if (noisy) begin
                @(negedge clk);
                drive_start(w, 1'($urandom_range(0, 1)));
            end
            @(posedge clk);
            #1;
            if (done_of(w)) begin
                lat = n;
                break;
            end
        end
        drive_start(w, 1'b0);
        check({tag, " latency"}, 65'(lat), 65'(exp_lat));
        check({tag, " result"}, result_of(w), exp);
        @(posedge clk);
        #1;
        check({tag, " done/busy low"}, 65'({done_of(w), busy_of(w)}), 65'd0);
        check({tag, " result held"}, result_of(w), exp);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        int          seen;

        clr = 1'b1;
        start32 = 1'b0; start8 = 1'b0;
        op32 = '0; op8 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        #12;
        check("reset busy/done/dbz", 65'({busy32, done32, dbz32, busy8, done8, dbz8}), 65'd0);
        check("reset result32", 65'(result32), 65'd0);
        check("reset result8", 65'(result8), 65'd0);
        @(negedge clk);
        clr = 1'b0;

        run_op(32, ADD, 32'hFFFFFFFF, 32'd2, 1'b0, 65'h1, 1, "add wrap");
        run_op(32, SHRA, 32'h80000010, 32'h24, 1'b0, 65'hF8000001, 1, "shra");
        run_op(32, ROL, 32'h80000001, 32'd1, 1'b0, 65'h3, 1, "rol");
        run_op(32, MUL, 32'hFFFFFFFD, 32'd7, 1'b1, {1'b0, 64'hFFFFFFFF_FFFFFFEB}, 34, "mul -3*7");
        run_op(32, DIV, 32'hFFFFFFEF, 32'd5, 1'b1, {1'b0, 64'hFFFFFFFE_FFFFFFFD}, 34, "div -17/5");
        run_op(32, DIV, 32'd9, 32'd0, 1'b0, {1'b1, 64'h00000009_FFFFFFFF}, 1, "div by zero");
        run_op(32, SHR, 32'h00001234, 32'h40, 1'b0, 65'h1234, 1, "shr amount 0");
        run_op(32, DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, {1'b0, 64'h00000000_80000000}, 34,
               "div minneg/-1");
        run_op(32, 5'b11111, 32'h1234, 32'h5678, 1'b0, 65'h0, 1, "illegal op");
        run_op(32, NEG, 32'hDEAD, 32'd1, 1'b0, 65'hFFFFFFFF, 1, "neg");
        run_op(32, NOT_, 32'hDEAD, 32'h0F0F0F0F, 1'b0, 65'hF0F0F0F0, 1, "not");

        // Abandon a multiply with clr part-way through.
        @(negedge clk);
        op32 = MUL; a32 = 32'd1234; b32 = 32'd5678;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr outputs", 65'({busy32, done32, dbz32}), 65'd0);
        check("clr result", 65'(result32), 65'd0);
        @(negedge clk);
        clr = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32) seen++;
        end
        check("no done after clr", 65'(seen), 65'd0);
        run_op(32, ADD, 32'd1, 32'd1, 1'b0, 65'h2, 1, "add after clr");

        run_op(8, MUL, 32'h80, 32'h80, 1'b0, 65'h4000, 10, "mul8 0x80*0x80");
        run_op(8, DIV, 32'h80, 32'hFF, 1'b0, 65'h0080, 10, "div8 0x80/0xff");

        for (int i = 0; i < 48; i++) begin
            op = ($urandom_range(0, 12) == 0) ? 5'($urandom_range(19, 31))
                                              : LEGAL[$urandom_range(0, 12)];
            a = pick_operand(32);
            b = pick_operand(32);
            run_op(32, op, a, b, 1'($urandom_range(0, 1)), ref_model(32, op, a, b),
                   lat_of(32, op, b), $sformatf("rand32 #%0d op %b", i, op));
        end
        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? MUL : DIV)
                                             : LEGAL[$urandom_range(0, 12)];
            a = pick_operand(8);
            b = pick_operand(8);
            run_op(8, op, a, b, 1'($urandom_range(0, 1)), ref_model(8, op, a, b),
                   lat_of(8, op, b), $sformatf("rand8 #%0d op %b", i, op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
